// File: rtl/mrv2_issue_sched_if.sv
// rtl/mrv2_issue_sched_if.sv - signal bundle between mrv2_issue_sched and its decode/flush/wb/FU neighbours
// Purpose: carries every scheduler port except clk_i/rst_i.
// Ports:
//   dec_*    decode enqueue (valid, thread, FU one-hot, payload, rs0/rs1/rd) and per-thread ready
//   flush_*  per-thread flush request
//   wb_*     writeback of one destination register
//   exec_fu_rdy_i  per-FU accept
//   issue_*  issued head instruction and its per-thread itag
// Modports: master = surrounding pipeline, slave = scheduler.
interface mrv2_issue_sched_if #(
  parameter int NUM_THREADS_P   = 8,
  parameter int NUM_FU_P        = 4,
  parameter int PAYLOAD_WIDTH_P = 64,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int ITAG_WIDTH_P    = 3
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);

  logic [NUM_THREADS_P-1:0]   dec_rdy_o;
  logic                       dec_vld_i;
  logic [TID_WIDTH_LP-1:0]    dec_tid_i;
  logic [NUM_FU_P-1:0]        dec_fu_req_i;
  logic [PAYLOAD_WIDTH_P-1:0] dec_payload_i;
  logic                       dec_rs0_vld_i, dec_rs1_vld_i, dec_rd_vld_i;
  logic [RF_ADDR_WIDTH_P-1:0] dec_rs0_addr_i, dec_rs1_addr_i, dec_rd_addr_i;
  logic                       flush_vld_i;
  logic [TID_WIDTH_LP-1:0]    flush_tid_i;
  logic                       wb_vld_i;
  logic [TID_WIDTH_LP-1:0]    wb_tid_i;
  logic [RF_ADDR_WIDTH_P-1:0] wb_rd_addr_i;
  logic [NUM_FU_P-1:0]        exec_fu_rdy_i;
  logic                       issue_vld_o;
  logic [TID_WIDTH_LP-1:0]    issue_tid_o;
  logic [NUM_FU_P-1:0]        issue_fu_req_o;
  logic [PAYLOAD_WIDTH_P-1:0] issue_payload_o;
  logic                       issue_rs0_vld_o, issue_rs1_vld_o, issue_rd_vld_o;
  logic [RF_ADDR_WIDTH_P-1:0] issue_rs0_addr_o, issue_rs1_addr_o, issue_rd_addr_o;
  logic [ITAG_WIDTH_P-1:0]    issue_itag_o;

  modport master (
    input  dec_rdy_o,
    output dec_vld_i, dec_tid_i, dec_fu_req_i, dec_payload_i,
    output dec_rs0_vld_i, dec_rs1_vld_i, dec_rd_vld_i,
    output dec_rs0_addr_i, dec_rs1_addr_i, dec_rd_addr_i,
    output flush_vld_i, flush_tid_i, wb_vld_i, wb_tid_i, wb_rd_addr_i, exec_fu_rdy_i,
    input  issue_vld_o, issue_tid_o, issue_fu_req_o, issue_payload_o,
    input  issue_rs0_vld_o, issue_rs1_vld_o, issue_rd_vld_o,
    input  issue_rs0_addr_o, issue_rs1_addr_o, issue_rd_addr_o, issue_itag_o
  );

  modport slave (
    output dec_rdy_o,
    input  dec_vld_i, dec_tid_i, dec_fu_req_i, dec_payload_i,
    input  dec_rs0_vld_i, dec_rs1_vld_i, dec_rd_vld_i,
    input  dec_rs0_addr_i, dec_rs1_addr_i, dec_rd_addr_i,
    input  flush_vld_i, flush_tid_i, wb_vld_i, wb_tid_i, wb_rd_addr_i, exec_fu_rdy_i,
    output issue_vld_o, issue_tid_o, issue_fu_req_o, issue_payload_o,
    output issue_rs0_vld_o, issue_rs1_vld_o, issue_rd_vld_o,
    output issue_rs0_addr_o, issue_rs1_addr_o, issue_rd_addr_o, issue_itag_o
  );
endinterface

// File: rtl/mrv2_issue_sched.sv
// rtl/mrv2_issue_sched.sv - multithreaded round-robin issue scheduler with per-thread buffers and scoreboards
// Purpose: per-thread decode FIFOs, per-thread register scoreboards, one issue per cycle
//          chosen round-robin among hazard-free heads whose FU is ready.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    mrv2_issue_sched_if.slave (decode, flush, writeback, FU ready, issue outputs)
// Optional feature: define MRV2_ISSUE_WB_BYPASS_EN to let a writeback unblock a
// dependent head in the same cycle; otherwise only the registered scoreboard is used.
module mrv2_issue_sched #(
  parameter int NUM_THREADS_P   = 8,
  parameter int DEC_BUF_SZ_P    = 4,
  parameter int NUM_FU_P        = 4,
  parameter int PAYLOAD_WIDTH_P = 64,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int ITAG_WIDTH_P    = 3,
  localparam int TID_WIDTH_LP   = $clog2(NUM_THREADS_P)
) (
  input logic               clk_i,
  input logic               rst_i,
  mrv2_issue_sched_if.slave bus
);
  localparam int PTR_W = $clog2(DEC_BUF_SZ_P);
  localparam int NREG  = 1 << RF_ADDR_WIDTH_P;

  typedef struct packed {
    logic [NUM_FU_P-1:0]        fu_req;
    logic [PAYLOAD_WIDTH_P-1:0] payload;
    logic                       rs0_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs0_addr;
    logic                       rs1_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs1_addr;
    logic                       rd_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rd_addr;
  } entry_t;

  entry_t                  buf_q    [NUM_THREADS_P][DEC_BUF_SZ_P];
  logic [PTR_W:0]          wr_ptr_q [NUM_THREADS_P];
  logic [PTR_W:0]          rd_ptr_q [NUM_THREADS_P];
  logic [NREG-1:0]         sb_q     [NUM_THREADS_P];
  logic [ITAG_WIDTH_P-1:0] itag_q   [NUM_THREADS_P];
  logic [TID_WIDTH_LP-1:0] last_q;

  entry_t                   dec_entry;
  entry_t                   head   [NUM_THREADS_P];
  logic [NREG-1:0]          wb_clr [NUM_THREADS_P];
  logic [NREG-1:0]          sb_chk [NUM_THREADS_P];
  logic [NREG-1:0]          sb_set;
  logic [NUM_THREADS_P-1:0] full, empty, flush_hit, enq_hit, elig, win_hit;
  logic                     found;
  logic [TID_WIDTH_LP-1:0]  win;

  // Per-thread status and eligibility of each buffer head.
  always_comb begin
    dec_entry.fu_req   = bus.dec_fu_req_i;
    dec_entry.payload  = bus.dec_payload_i;
    dec_entry.rs0_vld  = bus.dec_rs0_vld_i;
    dec_entry.rs0_addr = bus.dec_rs0_addr_i;
    dec_entry.rs1_vld  = bus.dec_rs1_vld_i;
    dec_entry.rs1_addr = bus.dec_rs1_addr_i;
    dec_entry.rd_vld   = bus.dec_rd_vld_i;
    dec_entry.rd_addr  = bus.dec_rd_addr_i;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      head[t]  = buf_q[t][rd_ptr_q[t][PTR_W-1:0]];
      empty[t] = (wr_ptr_q[t] == rd_ptr_q[t]);
      // Same index with opposite wrap bits means the writer lapped the reader.
      full[t]  = (wr_ptr_q[t][PTR_W] != rd_ptr_q[t][PTR_W]) &&
                 (wr_ptr_q[t][PTR_W-1:0] == rd_ptr_q[t][PTR_W-1:0]);
      flush_hit[t] = bus.flush_vld_i && (bus.flush_tid_i == TID_WIDTH_LP'(t));
      enq_hit[t]   = bus.dec_vld_i && (bus.dec_tid_i == TID_WIDTH_LP'(t)) &&
                     !full[t] && !flush_hit[t];
      wb_clr[t] = '0;
      if (bus.wb_vld_i && (bus.wb_tid_i == TID_WIDTH_LP'(t)))
        wb_clr[t][bus.wb_rd_addr_i] = 1'b1;
`ifdef MRV2_ISSUE_WB_BYPASS_EN
      sb_chk[t] = sb_q[t] & ~wb_clr[t];
`else
      sb_chk[t] = sb_q[t];
`endif
      elig[t] = !empty[t] && !flush_hit[t]
        && !(head[t].rs0_vld && (head[t].rs0_addr != '0) && sb_chk[t][head[t].rs0_addr])
        && !(head[t].rs1_vld && (head[t].rs1_addr != '0) && sb_chk[t][head[t].rs1_addr])
        && !(head[t].rd_vld  && (head[t].rd_addr  != '0) && sb_chk[t][head[t].rd_addr])
        && ((head[t].fu_req & bus.exec_fu_rdy_i) != '0);
    end
  end

  // Round-robin pick starting just after the last issuing thread; the
  // TID-width add wraps naturally because the thread count is a power of two.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_THREADS_P; k++) begin
      if (!found && elig[last_q + TID_WIDTH_LP'(k)]) begin
        found = 1'b1;
        win   = last_q + TID_WIDTH_LP'(k);
      end
    end
    win_hit = '0;
    if (found) win_hit[win] = 1'b1;
    sb_set = '0;
    if (found && head[win].rd_vld && (head[win].rd_addr != '0))
      sb_set[head[win].rd_addr] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
        sb_q[t]     <= '0;
        itag_q[t]   <= '0;
      end
      last_q <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
    end else begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        if (enq_hit[t]) begin
          buf_q[t][wr_ptr_q[t][PTR_W-1:0]] <= dec_entry;
          wr_ptr_q[t] <= wr_ptr_q[t] + 1'b1;
        end
        // Flush drops everything held; the same-cycle enqueue was already blocked.
        if (flush_hit[t])
          rd_ptr_q[t] <= wr_ptr_q[t];
        else if (win_hit[t])
          rd_ptr_q[t] <= rd_ptr_q[t] + 1'b1;
        // Clear first, then set, so an issue-set beats a same-bit writeback.
        sb_q[t] <= (sb_q[t] & ~wb_clr[t]) | (win_hit[t] ? sb_set : '0);
        if (win_hit[t]) itag_q[t] <= itag_q[t] + 1'b1;
      end
      if (found) last_q <= win;
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) bus.dec_rdy_o[t] = !full[t];
  end

  assign bus.issue_vld_o      = found;
  assign bus.issue_tid_o      = win;
  assign bus.issue_fu_req_o   = head[win].fu_req;
  assign bus.issue_payload_o  = head[win].payload;
  assign bus.issue_rs0_vld_o  = head[win].rs0_vld;
  assign bus.issue_rs0_addr_o = head[win].rs0_addr;
  assign bus.issue_rs1_vld_o  = head[win].rs1_vld;
  assign bus.issue_rs1_addr_o = head[win].rs1_addr;
  assign bus.issue_rd_vld_o   = head[win].rd_vld;
  assign bus.issue_rd_addr_o  = head[win].rd_addr;
  assign bus.issue_itag_o     = itag_q[win];
endmodule

// File: tb/tb_mrv2_issue_sched.sv
// tb/tb_mrv2_issue_sched.sv - self-checking bench for mrv2_issue_sched with a queue-based reference model
module tb_mrv2_issue_sched;
  localparam int NT = 8, D = 4, NF = 4, PW = 64, RA = 5, IW = 3, TW = 3;
`ifdef MRV2_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mrv2_issue_sched_if #(.NUM_THREADS_P(NT), .NUM_FU_P(NF), .PAYLOAD_WIDTH_P(PW),
                        .RF_ADDR_WIDTH_P(RA), .ITAG_WIDTH_P(IW)) bus ();
  mrv2_issue_sched #(.NUM_THREADS_P(NT), .DEC_BUF_SZ_P(D), .NUM_FU_P(NF), .PAYLOAD_WIDTH_P(PW),
                     .RF_ADDR_WIDTH_P(RA), .ITAG_WIDTH_P(IW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [NF-1:0] fu; logic [PW-1:0] pl;
    logic s0v; logic [RA-1:0] s0;
    logic s1v; logic [RA-1:0] s1;
    logic rdv; logic [RA-1:0] rd;
  } ent_t;

  ent_t mq [NT][$];
  bit   msb [NT][1<<RA];
  int   mitag [NT];
  int   mlast;
  int   infl_t[$], infl_r[$];

  int n_tests = 0, n_fail = 0;
  bit obs_vld; int obs_tid, obs_itag; logic [NT-1:0] obs_rdy;
  int iss_cnt [NT];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit hazard(input int t, input bit v, input logic [RA-1:0] a);
    bit wb_now;
    wb_now = bus.wb_vld_i && (int'(bus.wb_tid_i) == t) && (bus.wb_rd_addr_i == a);
    return v && (a != '0) && msb[t][a] && !(BYP && wb_now);
  endfunction

  task automatic idle_inputs();
    bus.dec_vld_i = 1'b0; bus.dec_tid_i = '0; bus.dec_fu_req_i = '0; bus.dec_payload_i = '0;
    bus.dec_rs0_vld_i = 1'b0; bus.dec_rs1_vld_i = 1'b0; bus.dec_rd_vld_i = 1'b0;
    bus.dec_rs0_addr_i = '0; bus.dec_rs1_addr_i = '0; bus.dec_rd_addr_i = '0;
    bus.flush_vld_i = 1'b0; bus.flush_tid_i = '0;
    bus.wb_vld_i = 1'b0; bus.wb_tid_i = '0; bus.wb_rd_addr_i = '0;
  endtask

  task automatic enq(input int t, input logic [NF-1:0] fu, input bit rdv, input int rd,
                     input bit s0v, input int s0, input bit s1v, input int s1);
    bus.dec_vld_i = 1'b1; bus.dec_tid_i = TW'(t); bus.dec_fu_req_i = fu;
    bus.dec_payload_i = {$urandom, $urandom};
    bus.dec_rd_vld_i = rdv; bus.dec_rd_addr_i = RA'(rd);
    bus.dec_rs0_vld_i = s0v; bus.dec_rs0_addr_i = RA'(s0);
    bus.dec_rs1_vld_i = s1v; bus.dec_rs1_addr_i = RA'(s1);
  endtask

  // One cycle: compare DUT against the model at negedge, advance the model, then clock.
  task automatic step();
    ent_t h, e; bit el [NT]; bit found; int w; bit acc;
    logic [NT-1:0] exp_rdy;
    int dt, ft;
    @(negedge clk);
    found = 1'b0; w = 0;
    for (int t = 0; t < NT; t++) begin
      el[t] = 1'b0;
      exp_rdy[t] = (mq[t].size() < D);
      if (mq[t].size() != 0 && !(bus.flush_vld_i && int'(bus.flush_tid_i) == t)) begin
        h = mq[t][0];
        el[t] = !hazard(t, h.s0v, h.s0) && !hazard(t, h.s1v, h.s1) &&
                !hazard(t, h.rdv, h.rd) && ((h.fu & bus.exec_fu_rdy_i) != '0);
      end
    end
    for (int k = 1; k <= NT; k++) begin
      if (!found && el[(mlast + k) % NT]) begin found = 1'b1; w = (mlast + k) % NT; end
    end
    chk("dec_rdy", 64'(bus.dec_rdy_o), 64'(exp_rdy));
    chk("issue_vld", 64'(bus.issue_vld_o), 64'(found));
    if (found) begin
      h = mq[w][0];
      chk("issue_tid", 64'(bus.issue_tid_o), 64'(w));
      chk("issue_fu", 64'(bus.issue_fu_req_o), 64'(h.fu));
      chk("issue_payload", bus.issue_payload_o, h.pl);
      chk("issue_rs0", 64'({bus.issue_rs0_vld_o, bus.issue_rs0_addr_o}), 64'({h.s0v, h.s0}));
      chk("issue_rs1", 64'({bus.issue_rs1_vld_o, bus.issue_rs1_addr_o}), 64'({h.s1v, h.s1}));
      chk("issue_rd", 64'({bus.issue_rd_vld_o, bus.issue_rd_addr_o}), 64'({h.rdv, h.rd}));
      chk("issue_itag", 64'(bus.issue_itag_o), 64'(mitag[w]));
    end
    obs_vld = bus.issue_vld_o; obs_tid = int'(bus.issue_tid_o);
    obs_itag = int'(bus.issue_itag_o); obs_rdy = bus.dec_rdy_o;
    if (obs_vld) iss_cnt[obs_tid]++;
    dt = int'(bus.dec_tid_i); ft = int'(bus.flush_tid_i);
    acc = bus.dec_vld_i && (mq[dt].size() < D) && !(bus.flush_vld_i && ft == dt);
    e = '{fu: bus.dec_fu_req_i, pl: bus.dec_payload_i, s0v: bus.dec_rs0_vld_i, s0: bus.dec_rs0_addr_i,
          s1v: bus.dec_rs1_vld_i, s1: bus.dec_rs1_addr_i, rdv: bus.dec_rd_vld_i, rd: bus.dec_rd_addr_i};
    if (bus.wb_vld_i) msb[int'(bus.wb_tid_i)][bus.wb_rd_addr_i] = 1'b0;
    if (found) begin
      h = mq[w].pop_front();
      mitag[w] = (mitag[w] + 1) % (1 << IW);
      mlast = w;
      if (h.rdv && h.rd != '0) begin
        msb[w][h.rd] = 1'b1;
        infl_t.push_back(w); infl_r.push_back(int'(h.rd));
      end
    end
    if (bus.flush_vld_i) mq[ft].delete();
    if (acc) mq[dt].push_back(e);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic clr_cnt();
    for (int t = 0; t < NT; t++) iss_cnt[t] = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.exec_fu_rdy_i = '1;
    for (int t = 0; t < NT; t++) begin
      mitag[t] = 0; iss_cnt[t] = 0;
      for (int r = 0; r < (1 << RA); r++) msb[t][r] = 1'b0;
    end
    mlast = NT - 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and in-order round robin across tid0..3.
    enq(0, 4'b0001, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    step();
    chk("reset_rdy", 64'(obs_rdy), 64'({NT{1'b1}}));
    chk("reset_no_issue", 64'(obs_vld), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) enq(k, 4'b0001, 1'b1, 0, 1'b0, 0, 1'b0, 0);
      step();
      chk("rr_vld", 64'(obs_vld), 64'(1));
      chk("rr_tid", 64'(obs_tid), 64'(k - 1));
      chk("rr_itag", 64'(obs_itag), 64'(0));
    end

    // RAW on x5 in tid2, released by writeback; x0 operand never stalls.
    enq(2, 4'b0001, 1'b1, 5, 1'b0, 0, 1'b0, 0);
    step();
    enq(2, 4'b0010, 1'b0, 0, 1'b1, 5, 1'b1, 0);
    step();
    chk("raw_prod_tid", 64'(obs_tid), 64'(2));
    chk("raw_prod_itag", 64'(obs_itag), 64'(1));
    step(); chk("raw_stall0", 64'(obs_vld), 64'(0));
    step(); chk("raw_stall1", 64'(obs_vld), 64'(0));
    bus.wb_vld_i = 1'b1; bus.wb_tid_i = 3'd2; bus.wb_rd_addr_i = 5'd5;
    step(); chk("raw_wb_cycle", 64'(obs_vld), 64'(BYP));
    if (BYP) chk("raw_cons_itag", 64'(obs_itag), 64'(2));
    step(); chk("raw_after_wb", 64'(obs_vld), 64'(!BYP));
    if (!BYP) chk("raw_cons_itag", 64'(obs_itag), 64'(2));

    // Fill tid1, fifth enqueue dropped, ready returns one cycle after an issue.
    bus.exec_fu_rdy_i = '0;
    for (int k = 0; k < 4; k++) begin enq(1, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0); bus.exec_fu_rdy_i = '0; step(); end
    enq(1, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0); step();
    chk("full_rdy", 64'(obs_rdy[1]), 64'(0));
    clr_cnt();
    bus.exec_fu_rdy_i = '1;
    step(); chk("full_issue_tid", 64'(obs_tid), 64'(1)); chk("full_rdy_still", 64'(obs_rdy[1]), 64'(0));
    step(); chk("full_rdy_back", 64'(obs_rdy[1]), 64'(1));
    repeat (4) step();
    chk("full_count", 64'(iss_cnt[1]), 64'(4));

    // Flush of tid3 holding 3 entries with a colliding enqueue; scoreboard survives.
    enq(3, 4'b0001, 1'b1, 7, 1'b0, 0, 1'b0, 0); step();
    step(); chk("fl_prod_tid", 64'(obs_tid), 64'(3));
    bus.exec_fu_rdy_i = '0;
    for (int k = 0; k < 3; k++) begin enq(3, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0); step(); end
    bus.exec_fu_rdy_i = '1;
    enq(3, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    bus.flush_vld_i = 1'b1; bus.flush_tid_i = 3'd3;
    step(); chk("fl_no_issue", 64'(obs_vld), 64'(0));
    step(); chk("fl_empty", 64'(obs_vld), 64'(0));
    enq(3, 4'b0001, 1'b0, 0, 1'b1, 7, 1'b0, 0); step();
    step(); chk("fl_sb_kept", 64'(obs_vld), 64'(0));
    bus.wb_vld_i = 1'b1; bus.wb_tid_i = 3'd3; bus.wb_rd_addr_i = 5'd7;
    step(); chk("fl_wb_cycle", 64'(obs_vld), 64'(BYP));
    step(); chk("fl_after_wb", 64'(obs_vld), 64'(!BYP));
    chk("fl_itag_kept", 64'(obs_itag), 64'(2));

    // tid0 waits for FU2 while tid1 keeps issuing.
    clr_cnt();
    bus.exec_fu_rdy_i = 4'b1011;
    enq(0, 4'b0100, 1'b0, 0, 1'b0, 0, 1'b0, 0); step();
    for (int k = 0; k < 3; k++) begin enq(1, 4'b0010, 1'b0, 0, 1'b0, 0, 1'b0, 0); step(); end
    repeat (2) step();
    chk("fu_stall_t0", 64'(iss_cnt[0]), 64'(0));
    chk("fu_other_t1", 64'(iss_cnt[1]), 64'(3));
    bus.exec_fu_rdy_i = '1;
    step(); chk("fu_ready_tid", 64'(obs_tid), 64'(0)); chk("fu_ready_vld", 64'(obs_vld), 64'(1));

    // Nine back-to-back issues from tid5: itag wraps 7 -> 0.
    enq(5, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0); step();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) enq(5, 4'b0001, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      step();
      chk("wrap_tid", 64'(obs_tid), 64'(5));
      chk("wrap_itag", 64'(obs_itag), 64'(k % 8));
    end

    // Randomized traffic against the model.
    infl_t.delete(); infl_r.delete();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 60)
        enq($urandom_range(0, NT - 1), NF'(1 << $urandom_range(0, NF - 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      bus.exec_fu_rdy_i = NF'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) begin
        bus.flush_vld_i = 1'b1; bus.flush_tid_i = TW'($urandom_range(0, NT - 1));
      end
      if (infl_t.size() != 0 && $urandom_range(0, 99) < 40) begin
        int i;
        i = $urandom_range(0, infl_t.size() - 1);
        bus.wb_vld_i = 1'b1; bus.wb_tid_i = TW'(infl_t[i]); bus.wb_rd_addr_i = RA'(infl_r[i]);
        infl_t.delete(i); infl_r.delete(i);
      end else if ($urandom_range(0, 99) < 5) begin
        bus.wb_vld_i = 1'b1; bus.wb_tid_i = TW'($urandom_range(0, NT - 1));
        bus.wb_rd_addr_i = RA'($urandom_range(0, 7));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
